// File: rtl/uart_tx_piso.sv
// UART transmit frame shifter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Build option: define UART_TX_TWO_STOP_EN to send two stop bits per frame.
module uart_tx_piso #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  baud_clk,
    input  logic                  reset_n,
    input  logic                  send,
    input  logic [DATA_WIDTH-1:0] reg_data,
    input  logic [1:0]            parity_type,
    input  logic                  parity_bit,
    output logic                  data_tx,
    output logic                  active_flag,
    output logic                  done_flag
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]            r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic [1:0]            r_ptype;
    logic                  r_pbit;
    logic                  r_tx;
    logic                  r_active;
    logic                  r_done;
`ifdef UART_TX_TWO_STOP_EN
    logic                  r_stop2;
`endif

    logic [2:0]    w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_load;
    logic          w_par_en;
    logic          w_tx_next;
    logic          w_active_next;
    logic          w_done_next;

    // Parity slot only for odd (01) and even (10); 00 and 11 both mean none.
    assign w_par_en = r_ptype[0] ^ r_ptype[1];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (send) begin
                    w_state_next = S_START;
                    w_load       = 1'b1;
                end
            end
            S_START: begin
                w_state_next = S_DATA;
                w_cnt_next   = '0;
            end
            S_DATA: begin
                if (r_cnt == LAST_BIT) begin
                    w_state_next = w_par_en ? S_PARITY : S_STOP;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_PARITY: w_state_next = S_STOP;
            S_STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                w_state_next = r_stop2 ? S_DONE : S_STOP;
`else
                w_state_next = S_DONE;
`endif
            end
            S_DONE: begin
                if (send) begin
                    w_state_next = S_START;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so each state's line level appears on its own cycle.
    always_comb begin
        w_tx_next     = 1'b1;
        w_active_next = 1'b0;
        w_done_next   = 1'b0;
        case (w_state_next)
            S_START: begin
                w_tx_next     = 1'b0;
                w_active_next = 1'b1;
            end
            S_DATA: begin
                w_tx_next     = r_shift[0];
                w_active_next = 1'b1;
            end
            S_PARITY: begin
                w_tx_next     = r_pbit;
                w_active_next = 1'b1;
            end
            S_STOP:  w_active_next = 1'b1;
            S_DONE:  w_done_next   = 1'b1;
            default: w_tx_next     = 1'b1;
        endcase
    end

    always_ff @(posedge baud_clk) begin
        if (reset_n) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_ptype  <= 2'b00;
            r_pbit   <= 1'b0;
            r_tx     <= 1'b1;
            r_active <= 1'b0;
            r_done   <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            r_stop2  <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_tx     <= w_tx_next;
            r_active <= w_active_next;
            r_done   <= w_done_next;
`ifdef UART_TX_TWO_STOP_EN
            r_stop2  <= (r_state == S_STOP) && !r_stop2;
`endif
            if (w_load) begin
                r_shift <= reg_data;
                r_ptype <= parity_type;
                r_pbit  <= parity_bit;
            end else if (w_state_next == S_DATA) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

    assign data_tx     = r_tx;
    assign active_flag = r_active;
    assign done_flag   = r_done;

endmodule

// File: tb/tb_uart_tx_piso.sv
// Scoreboard bench for uart_tx_piso: stimulus queues expected line bits, a monitor checks them each cycle.
module tb_uart_tx_piso;

`ifdef UART_TX_TWO_STOP_EN
    localparam int XS = 1;
`else
    localparam int XS = 0;
`endif

    logic       clk;
    logic       reset_n;
    logic       send;
    logic [7:0] reg_data;
    logic [1:0] parity_type;
    logic       parity_bit;
    logic       data_tx;
    logic       active_flag;
    logic       done_flag;

    uart_tx_piso #(.DATA_WIDTH(8)) dut (
        .baud_clk    (clk),
        .reset_n     (reset_n),
        .send        (send),
        .reg_data    (reg_data),
        .parity_type (parity_type),
        .parity_bit  (parity_bit),
        .data_tx     (data_tx),
        .active_flag (active_flag),
        .done_flag   (done_flag)
    );

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    int   start_q[$];
    int   cyc;
    int   n_cmp;
    int   n_err;
    logic exp_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, req);
        end
    endtask

    // bits[0] is the first bit on the line; the final one of n is the stop bit.
    task automatic push_frame(input logic [11:0] bits, input int n, input int start_cyc);
        for (int i = 0; i < n - 1; i++) begin
            exp_q.push_back('{b: bits[i], first: (i == 0), last: 1'b0});
        end
        if (XS != 0) exp_q.push_back('{b: 1'b1, first: 1'b0, last: 1'b0});
        exp_q.push_back('{b: bits[n-1], first: 1'b0, last: 1'b1});
        start_q.push_back(start_cyc);
    endtask

    task automatic push_partial(input logic [11:0] bits, input int n, input int start_cyc);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{b: bits[i], first: (i == 0), last: 1'b0});
        end
        start_q.push_back(start_cyc);
    endtask

    // Single frame from idle; inputs are scrambled right after capture to prove they are latched.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic pb,
                              input logic [11:0] bits, input int n);
        reg_data    = d;
        parity_type = pt;
        parity_bit  = pb;
        push_frame(bits, n, cyc + 1);
        send = 1'b1;
        @(negedge clk);
        send        = 1'b0;
        reg_data    = ~d;
        parity_type = ~pt;
        parity_bit  = ~pb;
        repeat (n + XS + 2) @(negedge clk);
    endtask

    // Monitor: one comparison set per cycle on the falling edge.
    initial begin : monitor
        exp_t e;
        logic nd;
        exp_done = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("done_flag", {31'd0, done_flag}, {31'd0, exp_done});
            nd = 1'b0;
            if (active_flag === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_active", {31'd0, active_flag}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.first) begin
                        if (start_q.size() > 0) check("start_cycle", cyc, start_q.pop_front());
                        else check("start_cycle_missing", cyc, 32'hFFFF_FFFF);
                    end
                    check("data_tx", {31'd0, data_tx}, {31'd0, e.b});
                    nd = e.last;
                end
            end else begin
                check("idle_line", {31'd0, data_tx}, 32'd1);
            end
            exp_done = nd;
        end
    end

    initial begin : stimulus
        int fl;
        int s;
        n_cmp       = 0;
        n_err       = 0;
        fl          = 10 + XS;
        reset_n     = 1'b1;
        send        = 1'b1;
        reg_data    = 8'h4A;
        parity_type = 2'b00;
        parity_bit  = 1'b0;

        // Reset held two edges with send high, then start bit on the first edge after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        push_frame(12'b1010010100, 10, cyc + 1);
        reset_n = 1'b0;
        @(negedge clk);
        send = 1'b0;
        repeat (fl + 2) @(negedge clk);

        send_frame(8'h4A, 2'b00, 1'b1, 12'b1010010100, 10);
        send_frame(8'h4A, 2'b01, 1'b0, 12'b10010010100, 11);
        send_frame(8'h4A, 2'b10, 1'b1, 12'b11010010100, 11);
        send_frame(8'h5A, 2'b11, 1'b1, 12'b1010110100, 10);

        // Back-to-back with send held; new data presented mid-frame lands in the second frame.
        reg_data    = 8'h4A;
        parity_type = 2'b00;
        parity_bit  = 1'b0;
        s = cyc + 1;
        push_frame(12'b1010010100, 10, s);
        push_frame(12'b1010110100, 10, s + fl + 1);
        send = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        reg_data   = 8'h5A;
        parity_bit = 1'b1;
        repeat (fl - 2) @(negedge clk);
        send = 1'b0;
        repeat (fl + 2) @(negedge clk);

        // Abort: reset sampled on the edge after data bit 4 is on the line.
        reg_data    = 8'h4A;
        parity_type = 2'b00;
        push_partial(12'b1010010100, 6, cyc + 1);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (4) @(negedge clk);

        send_frame(8'h5A, 2'b00, 1'b0, 12'b1010110100, 10);

        repeat (3) @(negedge clk);
        check("exp_queue_left", exp_q.size(), 32'd0);
        check("start_queue_left", start_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_piso.md
Name: uart_tx_piso

Overview:
- Parallel-in/serial-out frame shifter for the UART transmitter.
- Sits between the Tx data register and the `data_tx` line, clocked at the baud rate.
- Serialises an 8-bit word as: start bit (0), data bits LSB first, optional externally computed parity bit, stop bit (1).
- Reports frame progress on `active_flag` and completion on `done_flag`.

Parameters:
- DATA_WIDTH, default 8: number of data bits per frame. Only 8 is verified.

Ports:
- baud_clk  in  1  baud-rate clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-high reset (the codebase port name is kept; it asserts at 1).
- send  in  1  level request to transmit; sampled in IDLE and DONE.
- reg_data  in  DATA_WIDTH  word to transmit; captured at frame start.
- parity_type  in  2  00 = none, 01 = odd, 10 = even, 11 = none.
- parity_bit  in  1  precomputed parity value; captured at frame start; sent verbatim when parity is enabled.
- data_tx  out  1  serial line, idle high.
- active_flag  out  1  high while a frame is on the line (start through stop).
- done_flag  out  1  one-cycle pulse after the stop bit.

Behaviour:
- All outputs are registered.
- Reset (reset_n = 1 at a baud_clk edge):
  - state goes to IDLE; data_tx = 1, active_flag = 0, done_flag = 0.
  - shift register and bit counter cleared.
  - Reset has priority over everything and aborts any frame in progress immediately.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - data_tx = 1, active_flag = 0, done_flag = 0.
  - On an edge with send = 1: capture reg_data, parity_bit and parity_type into internal registers, go to START.
- START: data_tx = 0, active_flag = 1. Next edge goes to DATA with bit counter = 0.
- DATA:
  - data_tx = captured data bit[counter], LSB first.
  - The counter increments each edge.
  - After bit DATA_WIDTH-1: go to PARITY if the captured parity_type is 01 or 10, otherwise go to STOP.
- PARITY: data_tx = captured parity_bit. Next state is STOP.
- STOP: data_tx = 1, active_flag = 1. Next state is DONE.
- DONE:
  - data_tx = 1, active_flag = 0, done_flag = 1 for exactly this cycle.
  - Next edge: if send = 1, go to START and capture new inputs (back-to-back frames); otherwise go to IDLE.
- Each state lasts exactly one baud_clk period, except DATA, which lasts DATA_WIDTH periods.
- Frame length is 10 bit-times with no parity and 11 bit-times with parity.
- The edge that leaves IDLE drives the start bit, so the start bit appears 1 cycle after send is sampled.
- Frame timing with send held high: line stays high for stop + DONE (2 bit-times) between frames, then the next start bit follows.
- Input changes on reg_data, parity_bit or parity_type during a frame have no effect on the current frame.
- Deasserting send mid-frame does not abort the frame.
- parity_type = 11 behaves identically to 00.
- The parity bit is not computed internally; the DUT transmits parity_bit as supplied.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts two baud_clk periods (two stop bits, data_tx = 1, active_flag = 1 throughout). Frame length becomes 11 bit-times without parity and 12 with parity.
- Not defined: exactly one stop bit, as specified above.

Test Plan:
- Reset: reset_n = 1 for 2 edges with send = 1 → data_tx = 1, active_flag = 0, done_flag = 0 throughout. Release reset → start bit on the 1st edge after release.
- No parity: reg_data = 0x4A, parity_type = 00, pulse send → data_tx sequence 0,0,1,0,1,0,0,1,0,1. active_flag high for 10 cycles; done_flag high one cycle after the stop bit.
- Odd parity: reg_data = 0x4A, parity_type = 01, parity_bit = 0 → sequence 0,0,1,0,1,0,0,1,0,0,1 (11 bits). done_flag pulses once.
- Even parity plus type 11:
  - reg_data = 0x4A, parity_type = 10, parity_bit = 1 → parity slot = 1.
  - reg_data = 0x5A, parity_type = 11 → 10-bit frame 0,0,1,0,1,1,0,1,0,1 with no parity slot.
- Back-to-back: send held high for two frames, reg_data changed mid-frame → first frame unaffected; second frame starts the cycle after DONE carrying the new data.
- Abort: reset_n asserted during DATA bit 4 → next edge gives data_tx = 1, active_flag = 0, no done_flag pulse.
